// File: rtl/busytb_pkg.sv
// Shared defaults and derived widths for the busy table with checkpoint recovery.
package busytb_pkg;

    localparam int DEF_WIDTH = 7;
    localparam int DEF_NREAD = 4;
    localparam int DEF_NSET  = 4;
    localparam int DEF_NRST  = 4;
    localparam int DEF_NCKPT = 4;

    // Checkpoint tag width; a single slot still gets a one-bit tag.
    function automatic int ckpt_width(input int nckpt);
        return (nckpt > 1) ? $clog2(nckpt) : 1;
    endfunction

endpackage

// File: rtl/busytb_snap.sv
// Checkpoint bank: NCKPT snapshots of the busy table, each tracking wakeups after capture.
module busytb_snap
    import busytb_pkg::*;
#(
    parameter int  DEPTH = 1 << DEF_WIDTH,
    parameter int  NCKPT = DEF_NCKPT,
    localparam int CW    = ckpt_width(NCKPT)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DEPTH-1:0] i_clrVec,
    input  logic             i_save,
    input  logic [CW-1:0]    i_saveTag,
    input  logic [DEPTH-1:0] i_saveData,
    input  logic             i_restore,
    input  logic [CW-1:0]    i_restoreTag,
    output logic [DEPTH-1:0] o_restoreData
);

    logic [DEPTH-1:0] slot_r [NCKPT];

    assign o_restoreData = slot_r[i_restoreTag];

    // Capture or age each slot; a save coinciding with a restore is discarded.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCKPT; i++) begin
                slot_r[i] <= {DEPTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCKPT; i++) begin
                if (i_save && !i_restore && (i_saveTag == CW'(i))) begin
                    slot_r[i] <= i_saveData;
                end else begin
                    slot_r[i] <= slot_r[i] & ~i_clrVec;
                end
            end
        end
    end

endmodule

// File: rtl/busytb_ckpt.sv
// Physical-register busy table with dispatch/wakeup bypass and checkpoint save/restore.
module busytb_ckpt
    import busytb_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  NREAD = DEF_NREAD,
    parameter int  NSET  = DEF_NSET,
    parameter int  NRST  = DEF_NRST,
    parameter int  NCKPT = DEF_NCKPT,
    localparam int CW    = ckpt_width(NCKPT)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREAD*2*WIDTH-1:0] i_addr,
    output logic [NREAD*2-1:0]       o_data,
    input  logic [NSET*WIDTH-1:0]    i_setAddr,
    input  logic [NRST*WIDTH-1:0]    i_rstAddr,
    input  logic                     i_ckptSave,
    input  logic [CW-1:0]            i_ckptSaveTag,
    input  logic                     i_ckptRestore,
    input  logic [CW-1:0]            i_ckptRestoreTag
);

    localparam int DEPTH = 1 << WIDTH;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] set_vec_s;
    logic [DEPTH-1:0] clr_vec_s;
    logic [DEPTH-1:0] table_nxt_s;
    logic [DEPTH-1:0] snap_rd_s;

    // One-hot decode of mark-busy and wakeup ports; address 0 is never marked.
    always_comb begin
        set_vec_s = {DEPTH{1'b0}};
        clr_vec_s = {DEPTH{1'b0}};
        for (int k = 0; k < NSET; k++) begin
            set_vec_s[i_setAddr[k*WIDTH +: WIDTH]] = 1'b1;
        end
        for (int r = 0; r < NRST; r++) begin
            clr_vec_s[i_rstAddr[r*WIDTH +: WIDTH]] = 1'b1;
        end
        set_vec_s[0] = 1'b0;
        clr_vec_s[0] = 1'b0;
    end

    // Zero-latency reads: older-lane dependency beats wakeup bypass, which beats the table.
    always_comb begin
        o_data = {(NREAD*2){1'b0}};
        for (int s = 0; s < NREAD*2; s++) begin
            logic [WIDTH-1:0] rd_a;
            logic             dep;
            logic             wake;
            rd_a = i_addr[s*WIDTH +: WIDTH];
            dep  = 1'b0;
            wake = 1'b0;
            for (int k = 0; k < NSET; k++) begin
                dep = dep | ((k < (s / 2)) && (i_setAddr[k*WIDTH +: WIDTH] == rd_a));
            end
            for (int r = 0; r < NRST; r++) begin
                wake = wake | (i_rstAddr[r*WIDTH +: WIDTH] == rd_a);
            end
            o_data[s] = (rd_a != {WIDTH{1'b0}}) && (dep || (!wake && busy_r[rd_a]));
        end
    end

    // Restore replaces this cycle's sets but still honours its wakeups.
    always_comb begin
        if (i_ckptRestore) begin
            table_nxt_s = snap_rd_s & ~clr_vec_s;
        end else begin
            table_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
        end
    end

    // Busy table state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= table_nxt_s;
        end
    end

    busytb_snap #(
        .DEPTH (DEPTH),
        .NCKPT (NCKPT)
    ) u_snap (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clrVec      (clr_vec_s),
        .i_save        (i_ckptSave),
        .i_saveTag     (i_ckptSaveTag),
        .i_saveData    (table_nxt_s),
        .i_restore     (i_ckptRestore),
        .i_restoreTag  (i_ckptRestoreTag),
        .o_restoreData (snap_rd_s)
    );

endmodule

// File: tb/tb_busytb_ckpt.sv
// Directed self-checking bench for busytb_ckpt with hand-computed read vectors.
module tb_busytb_ckpt;

    localparam int W  = 7;
    localparam int NR = 4;
    localparam int NS = 4;
    localparam int NT = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NR*2*W-1:0]   addr;
    logic [NR*2-1:0]     data;
    logic [NS*W-1:0]     set_a;
    logic [NT*W-1:0]     rst_a;
    logic                save;
    logic [1:0]          save_tag;
    logic                restore;
    logic [1:0]          restore_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    busytb_ckpt dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_addr           (addr),
        .o_data           (data),
        .i_setAddr        (set_a),
        .i_rstAddr        (rst_a),
        .i_ckptSave       (save),
        .i_ckptSaveTag    (save_tag),
        .i_ckptRestore    (restore),
        .i_ckptRestoreTag (restore_tag)
    );

    task automatic idle();
        addr        = {(NR*2*W){1'b0}};
        set_a       = {(NS*W){1'b0}};
        rst_a       = {(NT*W){1'b0}};
        save        = 1'b0;
        save_tag    = 2'd0;
        restore     = 1'b0;
        restore_tag = 2'd0;
    endtask

    task automatic rd(input int lane, input logic [W-1:0] s2, input logic [W-1:0] s1);
        addr[lane*2*W +: 2*W] = {s2, s1};
    endtask

    task automatic setp(input int k, input logic [W-1:0] a);
        set_a[k*W +: W] = a;
    endtask

    task automatic clrp(input int k, input logic [W-1:0] a);
        rst_a[k*W +: W] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rd(0, 7'h4F, 7'h1F);
        rd(1, 7'h3F, 7'h2F);
        rd(2, 7'h10, 7'h50);
        rd(3, 7'h7F, 7'h01);
        #1;
        exp = 8'h00;
        if (data !== exp) begin bad++; $display("FAIL reset_read got=%h want=%h", data, exp); end
        total++;
        rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_set_clear();
        logic [7:0] exp;
        idle();
        setp(0, 7'h1F); setp(1, 7'h2F); setp(2, 7'h3F); setp(3, 7'h4F);
        rd(3, 7'h4F, 7'h1F);
        #1;
        exp = 8'h40;
        if (data !== exp) begin bad++; $display("FAIL s1_dep_lane3 got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        rd(0, 7'h4F, 7'h1F); rd(1, 7'h3F, 7'h2F); rd(2, 7'h20, 7'h00);
        #1;
        exp = 8'h0F;
        if (data !== exp) begin bad++; $display("FAIL s1_read_set got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        rd(0, 7'h4F, 7'h1F);
        clrp(0, 7'h1F);
        #1;
        exp = 8'h02;
        if (data !== exp) begin bad++; $display("FAIL s1_wake_bypass got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        rd(0, 7'h4F, 7'h1F); rd(1, 7'h3F, 7'h2F);
        #1;
        exp = 8'h0E;
        if (data !== exp) begin bad++; $display("FAIL s1_after_clear got=%h want=%h", data, exp); end
        total++;
        tick();
    endtask

    task automatic test_set_wins();
        logic [7:0] exp;
        idle();
        clrp(0, 7'h2F);
        tick();
        idle();
        setp(0, 7'h00); setp(1, 7'h2F); clrp(2, 7'h2F);
        rd(0, 7'h2F, 7'h00); rd(1, 7'h00, 7'h2F); rd(2, 7'h00, 7'h2F); rd(3, 7'h00, 7'h00);
        #1;
        exp = 8'h10;
        if (data !== exp) begin bad++; $display("FAIL s2_same_cycle got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        setp(1, 7'h33); setp(2, 7'h33); clrp(0, 7'h3F); clrp(3, 7'h3F);
        rd(0, 7'h2F, 7'h00); rd(3, 7'h00, 7'h00);
        #1;
        exp = 8'h02;
        if (data !== exp) begin bad++; $display("FAIL s2_set_wins got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        rd(0, 7'h3F, 7'h33);
        #1;
        exp = 8'h01;
        if (data !== exp) begin bad++; $display("FAIL s2_duplicates got=%h want=%h", data, exp); end
        total++;
        clrp(1, 7'h33); clrp(2, 7'h33);
        tick();
        idle();
        rd(0, 7'h00, 7'h33);
        #1;
        exp = 8'h00;
        if (data !== exp) begin bad++; $display("FAIL s2_dup_clear got=%h want=%h", data, exp); end
        total++;
        tick();
    endtask

    task automatic test_intra_group();
        logic [7:0] exp;
        idle();
        setp(0, 7'h50); setp(2, 7'h51); clrp(1, 7'h50);
        rd(0, 7'h00, 7'h50); rd(1, 7'h51, 7'h00); rd(2, 7'h51, 7'h50); rd(3, 7'h51, 7'h00);
        #1;
        exp = 8'h90;
        if (data !== exp) begin bad++; $display("FAIL s3_lane_dep got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        rd(0, 7'h51, 7'h50);
        #1;
        exp = 8'h03;
        if (data !== exp) begin bad++; $display("FAIL s3_committed got=%h want=%h", data, exp); end
        total++;
        tick();
    endtask

    task automatic test_restore();
        logic [7:0] exp;
        idle();
        setp(0, 7'h10);
        tick();
        idle();
        save = 1'b1; save_tag = 2'd1;
        tick();
        idle();
        setp(0, 7'h11); clrp(0, 7'h10);
        rd(0, 7'h11, 7'h10);
        #1;
        exp = 8'h00;
        if (data !== exp) begin bad++; $display("FAIL s4_pre got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        restore = 1'b1; restore_tag = 2'd1;
        rd(0, 7'h11, 7'h10);
        #1;
        exp = 8'h02;
        if (data !== exp) begin bad++; $display("FAIL s4_restore_cycle got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        rd(0, 7'h11, 7'h10); rd(1, 7'h51, 7'h2F);
        #1;
        exp = 8'h0C;
        if (data !== exp) begin bad++; $display("FAIL s4_restored got=%h want=%h", data, exp); end
        total++;
        tick();
    endtask

    task automatic test_save_restore_same();
        logic [7:0] exp;
        idle();
        setp(0, 7'h70); save = 1'b1; save_tag = 2'd2;
        tick();
        idle();
        setp(0, 7'h71);
        tick();
        idle();
        save = 1'b1; save_tag = 2'd2; restore = 1'b1; restore_tag = 2'd2;
        setp(0, 7'h72);
        rd(0, 7'h71, 7'h70); rd(1, 7'h00, 7'h72);
        #1;
        exp = 8'h07;
        if (data !== exp) begin bad++; $display("FAIL s5_pre_restore got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        rd(0, 7'h71, 7'h70); rd(1, 7'h00, 7'h72);
        #1;
        exp = 8'h01;
        if (data !== exp) begin bad++; $display("FAIL s5_old_slot got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        setp(0, 7'h73);
        tick();
        idle();
        restore = 1'b1; restore_tag = 2'd2;
        tick();
        idle();
        rd(0, 7'h71, 7'h70); rd(1, 7'h72, 7'h73);
        #1;
        exp = 8'h01;
        if (data !== exp) begin bad++; $display("FAIL s5_save_dropped got=%h want=%h", data, exp); end
        total++;
        tick();
        idle();
        save = 1'b1; save_tag = 2'd1; setp(0, 7'h74);
        tick();
        idle();
        clrp(0, 7'h70);
        tick();
        idle();
        restore = 1'b1; restore_tag = 2'd1;
        tick();
        idle();
        rd(0, 7'h74, 7'h70); rd(1, 7'h2F, 7'h10);
        #1;
        exp = 8'h0A;
        if (data !== exp) begin bad++; $display("FAIL s5_overwrite got=%h want=%h", data, exp); end
        total++;
        tick();
    endtask

    task automatic test_reset_midstream();
        logic [7:0] exp;
        idle();
        save = 1'b1; save_tag = 2'd0;
        tick();
        idle();
        rst_n = 1'b0;
        setp(0, 7'h40); setp(1, 7'h41);
        restore = 1'b1; restore_tag = 2'd0;
        save = 1'b1; save_tag = 2'd3;
        tick();
        rst_n = 1'b1;
        idle();
        rd(0, 7'h41, 7'h40); rd(1, 7'h4F, 7'h2F); rd(2, 7'h74, 7'h51); rd(3, 7'h50, 7'h00);
        #1;
        exp = 8'h00;
        if (data !== exp) begin bad++; $display("FAIL s6_after_reset got=%h want=%h", data, exp); end
        total++;
        for (int t = 0; t < NT; t++) begin
            tick();
            idle();
            restore = 1'b1; restore_tag = 2'(t);
            tick();
            idle();
            rd(0, 7'h41, 7'h40); rd(1, 7'h4F, 7'h2F); rd(2, 7'h74, 7'h51); rd(3, 7'h50, 7'h00);
            #1;
            exp = 8'h00;
            if (data !== exp) begin bad++; $display("FAIL s6_restore_slot%0d got=%h want=%h", t, data, exp); end
            total++;
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_set_clear();
        test_set_wins();
        test_intra_group();
        test_restore();
        test_save_restore_same();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
